// File: rtl/onehot_decoder_pipe.sv
// Pipelined one-hot decoder: expands LANES 3-bit selector codes into 8-bit one-hot
// select words behind a valid/ready stream with a one-entry skid buffer.
module onehot_decoder_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*LANES-1:0]   in_code,
  input  logic [LANES-1:0]     in_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_onehot,
  input  logic                 clear_count,
  output logic [CNT_W-1:0]     zero_count
);

  localparam int DW = 8 * LANES;

  logic [DW-1:0]    dec_data;
  logic [DW-1:0]    out_data_reg, out_data_next;
  logic [DW-1:0]    skid_data_reg, skid_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             in_ready_reg;
  logic [CNT_W:0]   pop_count;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             accept, emit;

  assign accept     = in_valid & in_ready_reg;
  assign emit       = out_valid_reg & out_ready;
  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_onehot = out_data_reg;
  assign zero_count = cnt_reg;

  // Decode ahead of storage so both OUT and SKID hold ready-to-use select words.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign dec_data[8*gi +: 8] = in_zero[gi] ? 8'h00 : (8'h01 << in_code[3*gi +: 3]);
    end
  endgenerate

  always_comb begin
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;
    if (!out_valid_reg || emit) begin
      if (skid_valid_reg) begin
        out_data_next   = skid_data_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        out_valid_next = accept;
        if (accept) begin
          out_data_next = dec_data;
        end
      end
    end else if (accept) begin
      // OUT is stalled: park the beat in SKID; in_ready drops next cycle.
      skid_data_next  = dec_data;
      skid_valid_next = 1'b1;
    end
  end

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_count = pop_count + {{CNT_W{1'b0}}, in_zero[i]};
    end
    cnt_sum  = {1'b0, cnt_reg} + pop_count;
    cnt_next = cnt_reg;
    if (clear_count) begin
      cnt_next = accept ? pop_count[CNT_W-1:0] : '0;
    end else if (accept) begin
      // The sum carries out only on overflow since pop_count is far below 2^CNT_W.
      cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      cnt_reg        <= '0;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
      cnt_reg        <= cnt_next;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe: a beat queue plus an integer counter
// model predict every output; directed steps are mixed with random traffic.
module tb_onehot_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_code = '0;
  logic [3:0]  in_zero = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_onehot;
  logic        clear_count = 1'b0;
  logic [15:0] zero_count;

  int n_checks = 0;
  int n_fail = 0;

  // Model: beats accepted but not yet emitted, in arrival order.
  logic [31:0] q[$];
  int          mcnt = 0;
  logic        last_acc = 1'b0;

  onehot_decoder_pipe #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot),
    .clear_count(clear_count), .zero_count(zero_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_dec(input logic [11:0] c, input logic [3:0] z);
    longint res = 0;
    for (int l = 0; l < 4; l++) begin
      int code = (int'(c) >> (3 * l)) & 7;
      if (!z[l]) res = res + (longint'(2 ** code) * longint'(2 ** (8 * l)));
    end
    return res[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
    chk("zero_count", {48'd0, zero_count}, 64'(mcnt));
    if (q.size() > 0) chk("out_onehot", {32'd0, out_onehot}, {32'd0, q[0]});
  endtask

  // One clock of stimulus: drive at the falling edge, update model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input logic v, input logic [11:0] c, input logic [3:0] z,
                      input logic r, input logic clr);
    logic acc, emt;
    int   pop;
    in_valid = v; in_code = c; in_zero = z; out_ready = r; clear_count = clr;
    acc = v && (q.size() < 2);
    emt = r && (q.size() > 0);
    @(posedge clk);
    pop = 0;
    for (int l = 0; l < 4; l++) pop += int'(z[l]);
    if (emt) void'(q.pop_front());
    if (acc) q.push_back(model_dec(c, z));
    if (clr) mcnt = acc ? pop : 0;
    else if (acc) mcnt = (mcnt + pop > 65535) ? 65535 : mcnt + pop;
    last_acc = acc;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [11:0] c_a, c_b, c_c;

    // Reset state, checked before any edge releases it.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_onehot", {32'd0, out_onehot}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_zero_count", {48'd0, zero_count}, 64'd0);
    rst_n = 1'b1;

    // Codes 7,3,0,5 on lanes 0..3.
    step(1'b1, {3'd5, 3'd0, 3'd3, 3'd7}, 4'b0000, 1'b1, 1'b0);
    chk("first_onehot", {32'd0, out_onehot}, 64'h20010880);
    chk("first_valid", {63'd0, out_valid}, 64'd1);
    chk("first_count", {48'd0, zero_count}, 64'd0);

    step(1'b1, {3'd2, 3'd2, 3'd2, 3'd2}, 4'b1010, 1'b1, 1'b0);
    chk("zero_lanes_onehot", {32'd0, out_onehot}, 64'h00040004);
    chk("zero_lanes_count", {48'd0, zero_count}, 64'd2);

    // Ten back-to-back beats at full throughput.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 12'($urandom), 4'($urandom), 1'b1, 1'b0);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    step(1'b0, 12'd0, 4'd0, 1'b1, 1'b0);

    // Backpressure: A in OUT, B into SKID, C held upstream.
    c_a = {3'd0, 3'd1, 3'd2, 3'd3};
    c_b = {3'd4, 3'd5, 3'd6, 3'd7};
    c_c = {3'd1, 3'd1, 3'd6, 3'd6};
    step(1'b1, c_a, 4'b0000, 1'b1, 1'b0);
    step(1'b1, c_b, 4'b0000, 1'b0, 1'b0);
    chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
    chk("skid_hold_a", {32'd0, out_onehot}, {32'd0, model_dec(c_a, 4'b0000)});
    step(1'b1, c_c, 4'b0000, 1'b0, 1'b0);
    chk("skid_c_held", {63'd0, last_acc}, 64'd0);
    step(1'b1, c_c, 4'b0000, 1'b1, 1'b0);
    chk("skid_emit_b", {32'd0, out_onehot}, {32'd0, model_dec(c_b, 4'b0000)});
    step(1'b1, c_c, 4'b0000, 1'b1, 1'b0);
    chk("skid_emit_c", {32'd0, out_onehot}, {32'd0, model_dec(c_c, 4'b0000)});
    step(1'b0, 12'd0, 4'd0, 1'b1, 1'b0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, 12'($urandom), 4'($urandom), ($urandom % 3) != 0,
           ($urandom % 16) == 0);
    end

    // Saturation: clear, climb to 0xFFFE, then overflow and hold.
    step(1'b1, 12'($urandom), 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 16383; i++) step(1'b1, 12'($urandom), 4'b1111, 1'b1, 1'b0);
    step(1'b1, 12'($urandom), 4'b0011, 1'b1, 1'b0);
    chk("preload_count", {48'd0, zero_count}, 64'hFFFE);
    step(1'b1, 12'($urandom), 4'b1111, 1'b1, 1'b0);
    chk("sat_count", {48'd0, zero_count}, 64'hFFFF);
    step(1'b1, 12'($urandom), 4'b1111, 1'b1, 1'b0);
    chk("sat_hold", {48'd0, zero_count}, 64'hFFFF);
    step(1'b1, 12'($urandom), 4'b0011, 1'b1, 1'b1);
    chk("clear_load", {48'd0, zero_count}, 64'd2);
    step(1'b0, 12'($urandom), 4'b1111, 1'b1, 1'b1);
    chk("clear_idle", {48'd0, zero_count}, 64'd0);

    // Fill OUT and SKID, then reset between edges.
    step(1'b1, c_a, 4'b0101, 1'b1, 1'b0);
    step(1'b1, c_b, 4'b0001, 1'b0, 1'b0);
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_out_onehot", {32'd0, out_onehot}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    chk("async_zero_count", {48'd0, zero_count}, 64'd0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 12'($urandom), 4'($urandom), 1'b1, 1'b0);

    for (int i = 0; i < 100; i++) begin
      step(($urandom % 2) != 0, 12'($urandom), 4'($urandom), ($urandom % 2) != 0, 1'b0);
    end
    step(1'b0, 12'd0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 12'd0, 4'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
